// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings, state type and size helper for the memory handshake controller
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Number of bytes touched by an access of the given size encoding.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      SZ_BYTE: n = 4'd1;
      SZ_HALF: n = 4'd2;
      SZ_WORD: n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - per-beat wait counter for the RAM strobe phase
module mem_wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic sample_ok,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Count strobe cycles; saturate at the last allowed value so a late exit cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  // The first strobe cycle may still see the previous access's MFC, so it never qualifies.
  assign sample_ok = (count != '0);
  assign expired   = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_handshake_ctrl.sv
// rtl/mem_handshake_ctrl.sv - load/store sequencer for the big-endian asynchronous RAM handshake
module mem_handshake_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        RW,
  input  logic [7:0]  Addr,
  input  logic [1:0]  Size,
  input  logic [63:0] WData,
  output logic [63:0] RData,
  output logic        Done,
  output logic        Err,
  output logic        Busy,
  output logic        MemEnable,
  output logic        MemRW,
  output logic [7:0]  MemAddr,
  output logic [1:0]  MemSize,
  output logic [31:0] MemDataOut,
  input  logic [31:0] MemDataIn,
  input  logic        MemMFC
);

  state_t      state;
  logic        rw_q;
  logic [7:0]  addr_q;
  logic [1:0]  size_q;
  logic [63:0] wdata_q;
  logic        beat_q;

  logic        timer_clear;
  logic        timer_enable;
  logic        sample_ok;
  logic        expired;
  logic [8:0]  end_addr;
  logic        range_bad;

  // Last byte touched by the incoming request; bit 8 set means it runs off the 256-byte RAM.
  assign end_addr  = {1'b0, Addr} + {5'b0, size_bytes(Size)} - 9'd1;
  assign range_bad = end_addr[8];

  assign timer_clear  = (state != ST_STROBE);
  assign timer_enable = (state == ST_STROBE);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .clear     (timer_clear),
    .enable    (timer_enable),
    .sample_ok (sample_ok),
    .expired   (expired)
  );

  // Request sequencer: every output is registered and set on the edge entering its state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      rw_q       <= 1'b1;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      wdata_q    <= '0;
      beat_q     <= 1'b0;
      RData      <= '0;
      Done       <= 1'b0;
      Err        <= 1'b0;
      Busy       <= 1'b0;
      MemEnable  <= 1'b0;
      MemRW      <= 1'b1;
      MemAddr    <= '0;
      MemSize    <= SZ_BYTE;
      MemDataOut <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Req) begin
            rw_q    <= RW;
            addr_q  <= Addr;
            size_q  <= Size;
            wdata_q <= WData;
            beat_q  <= 1'b0;
            RData   <= '0;
            Busy    <= 1'b1;
            if (range_bad) begin
              Err   <= 1'b1;
              state <= ST_RESP;
            end else begin
              Err        <= 1'b0;
              MemAddr    <= Addr;
              MemRW      <= RW;
              MemSize    <= (Size == SZ_DWORD) ? SZ_WORD : Size;
              MemDataOut <= (Size == SZ_DWORD) ? WData[63:32] : WData[31:0];
              state      <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          MemEnable <= 1'b1;
          state     <= ST_STROBE;
        end

        ST_STROBE: begin
          if (sample_ok && MemMFC) begin
            if (rw_q) begin
              case (size_q)
                SZ_BYTE: RData <= {56'b0, MemDataIn[7:0]};
                SZ_HALF: RData <= {48'b0, MemDataIn[15:0]};
                SZ_WORD: RData <= {32'b0, MemDataIn};
                default: begin
                  if (beat_q) RData[31:0]  <= MemDataIn;
                  else        RData[63:32] <= MemDataIn;
                end
              endcase
            end
            MemEnable <= 1'b0;
            state     <= ST_RELEASE;
          end else if (expired) begin
            Err       <= 1'b1;
            MemEnable <= 1'b0;
            state     <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if ((size_q == SZ_DWORD) && !beat_q && !Err) begin
            beat_q     <= 1'b1;
            MemAddr    <= addr_q + 8'd4;
            MemDataOut <= wdata_q[31:0];
            state      <= ST_SETUP;
          end else begin
            Done  <= 1'b1;
            state <= ST_RESP;
          end
        end

        ST_RESP: begin
          // A range error arrives here with Done still low and raises it one cycle later.
          if (Done) begin
            Done  <= 1'b0;
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            Done <= 1'b1;
          end
        end

        default: begin
          MemEnable <= 1'b0;
          Done      <= 1'b0;
          Busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// tb/tb_mem_handshake_ctrl.sv - self-checking bench with RAM model and request-level reference
module tb_mem_handshake_ctrl;
  import mem_ctrl_pkg::*;

  localparam int TO = 16;

  logic        Clk;
  logic        Reset_n;
  logic        Req;
  logic        RW;
  logic [7:0]  Addr;
  logic [1:0]  Size;
  logic [63:0] WData;
  logic [63:0] RData;
  logic        Done;
  logic        Err;
  logic        Busy;
  logic        MemEnable;
  logic        MemRW;
  logic [7:0]  MemAddr;
  logic [1:0]  MemSize;
  logic [31:0] MemDataOut;
  logic [31:0] MemDataIn;
  logic        MemMFC;

  int checks = 0;
  int failures = 0;

  mem_handshake_ctrl #(.TIMEOUT(TO)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Req        (Req),
    .RW         (RW),
    .Addr       (Addr),
    .Size       (Size),
    .WData      (WData),
    .RData      (RData),
    .Done       (Done),
    .Err        (Err),
    .Busy       (Busy),
    .MemEnable  (MemEnable),
    .MemRW      (MemRW),
    .MemAddr    (MemAddr),
    .MemSize    (MemSize),
    .MemDataOut (MemDataOut),
    .MemDataIn  (MemDataIn),
    .MemMFC     (MemMFC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RAM model: big-endian bytes, MFC after ram_delay enable cycles (0 = never answers)
  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  int ram_delay = 1;
  bit ram_sticky = 1'b0;
  int ram_cnt = 0;
  bit ram_loaded = 1'b0;

  initial MemMFC = 1'b0;

  always @(posedge Clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < 256; k++) ram[k] <= 8'(k * 37 + 11);
      ram_loaded <= 1'b1;
    end else if (MemEnable) begin
      if (ram_delay != 0 && ram_cnt + 1 == ram_delay && !MemRW) begin
        case (MemSize)
          2'b00: ram[MemAddr] <= MemDataOut[7:0];
          2'b01: begin
            ram[MemAddr]          <= MemDataOut[15:8];
            ram[8'(MemAddr + 1)]  <= MemDataOut[7:0];
          end
          default: begin
            ram[MemAddr]          <= MemDataOut[31:24];
            ram[8'(MemAddr + 1)]  <= MemDataOut[23:16];
            ram[8'(MemAddr + 2)]  <= MemDataOut[15:8];
            ram[8'(MemAddr + 3)]  <= MemDataOut[7:0];
          end
        endcase
      end
      MemMFC  <= (ram_delay != 0) && (ram_cnt + 1 >= ram_delay);
      ram_cnt <= ram_cnt + 1;
    end else begin
      ram_cnt <= 0;
      if (!ram_sticky) MemMFC <= 1'b0;
    end
  end

  always @* begin
    case (MemSize)
      2'b00:   MemDataIn = {24'b0, ram[MemAddr]};
      2'b01:   MemDataIn = {16'b0, ram[MemAddr], ram[8'(MemAddr + 1)]};
      default: MemDataIn = {ram[MemAddr], ram[8'(MemAddr + 1)], ram[8'(MemAddr + 2)], ram[8'(MemAddr + 3)]};
    endcase
  end

  // Bus monitor: strobe count, length of the latest strobe, and protocol rule violations
  int pulses_total = 0;
  int last_hi = 0;
  int low_run = 100;
  int gap_viol = 0;
  int size_viol = 0;
  bit en_prev = 1'b0;

  always @(negedge Clk) begin
    if (MemEnable) begin
      if (!en_prev) begin
        pulses_total++;
        last_hi = 0;
        if (low_run < 2) gap_viol++;
      end
      last_hi++;
      if (MemSize == 2'b11) size_viol++;
      low_run = 0;
    end else begin
      low_run++;
    end
    en_prev = MemEnable;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input bit rw, input logic [7:0] addr, input logic [1:0] size,
                        input logic [63:0] wd, input int delay, input string tag);
    int n;
    bit rerr;
    bit tout;
    int s;
    int exp_lat;
    int exp_pulses;
    int exp_hi;
    logic [63:0] exp_rd;
    int p0;
    int lat;
    bit seen;

    n = 1 << size;
    rerr = (int'(addr) + n - 1) > 255;
    tout = !rerr && (delay == 0);
    exp_rd = '0;
    if (!rerr && !tout) begin
      for (int k = 0; k < n; k++) begin
        if (rw) exp_rd = (exp_rd << 8) | 64'(ref_mem[int'(addr) + k]);
        else    ref_mem[int'(addr) + k] = wd[8 * (n - 1 - k) +: 8];
      end
    end
    s = ((delay < 1) ? 1 : delay) + 1;
    if (rerr) begin
      exp_lat = 1; exp_pulses = 0; exp_hi = 0;
    end else if (tout) begin
      exp_lat = TO + 2; exp_pulses = 1; exp_hi = TO;
    end else if (size == SZ_DWORD) begin
      exp_lat = 2 * s + 4; exp_pulses = 2; exp_hi = s;
    end else begin
      exp_lat = s + 2; exp_pulses = 1; exp_hi = s;
    end

    ram_delay = delay;
    @(negedge Clk);
    Req = 1'b1; RW = rw; Addr = addr; Size = size; WData = wd;
    p0 = pulses_total;
    @(posedge Clk);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 80) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
      seen = Done;
    end
    chk({tag, "_done"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_err"}, 64'(Err), 64'(rerr || tout));
    chk({tag, "_rdata"}, RData, exp_rd);
    chk({tag, "_busy"}, 64'(Busy), 64'd1);
    chk({tag, "_pulses"}, 64'(pulses_total - p0), 64'(exp_pulses));
    if (exp_pulses > 0) chk({tag, "_enhigh"}, 64'(last_hi), 64'(exp_hi));
    Req = 1'b0;
    @(negedge Clk);
    chk({tag, "_idle"}, {62'b0, Busy, Done}, 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k * 37 + 11);
    Reset_n = 1'b0;
    Req = 1'b0; RW = 1'b1; Addr = '0; Size = '0; WData = '0;
    repeat (3) @(negedge Clk);
    chk("rst_outputs", {RData[7:0], 3'b0, Done, Err, Busy, MemEnable, MemRW}, {8'h00, 8'h01});
    chk("rst_rdata", RData, 64'd0);
    chk("rst_bus", {MemAddr, 6'b0, MemSize, MemDataOut}, 48'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    do_req(1'b0, 8'h10, SZ_WORD, 64'hDEADBEEF, 1, "wr_word");
    do_req(1'b1, 8'h10, SZ_WORD, 64'h0, 1, "rd_word");
    chk("rd_word_value", RData, 64'h00000000DEADBEEF);
    do_req(1'b0, 8'h20, SZ_DWORD, 64'h0011223344556677, 1, "wr_dword");
    do_req(1'b1, 8'h23, SZ_BYTE, 64'h0, 1, "rd_byte");
    chk("rd_byte_value", RData, 64'h33);
    do_req(1'b1, 8'h26, SZ_HALF, 64'h0, 1, "rd_half");
    chk("rd_half_value", RData, 64'h6677);
    do_req(1'b1, 8'h20, SZ_DWORD, 64'h0, 1, "rd_dword");
    chk("rd_dword_value", RData, 64'h0011223344556677);
    do_req(1'b1, 8'hFC, SZ_DWORD, 64'h0, 1, "range_dword");
    do_req(1'b0, 8'hFE, SZ_WORD, 64'h12345678, 1, "range_word");
    do_req(1'b1, 8'hFF, SZ_BYTE, 64'h0, 1, "edge_byte");
    do_req(1'b1, 8'h30, SZ_WORD, 64'h0, 0, "tout_word");
    do_req(1'b0, 8'h40, SZ_DWORD, 64'hCAFEF00D12345678, 0, "tout_dword");

    ram_sticky = 1'b1;
    do_req(1'b1, 8'h10, SZ_WORD, 64'h0, 2, "stale_prep");
    chk("stale_mfc_held", 64'(MemMFC), 64'd1);
    do_req(1'b1, 8'h10, SZ_WORD, 64'h0, 5, "stale_delay5");
    ram_sticky = 1'b0;

    // Reset in the middle of a strobe
    ram_delay = 0;
    @(negedge Clk);
    Req = 1'b1; RW = 1'b1; Addr = 8'h50; Size = SZ_WORD;
    repeat (4) @(negedge Clk);
    chk("mid_strobe_en", 64'(MemEnable), 64'd1);
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_async_en", 64'(MemEnable), 64'd0);
    chk("rst_async_busy", 64'(Busy), 64'd0);
    Req = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    do_req(1'b1, 8'h10, SZ_WORD, 64'h0, 1, "post_rst");
    chk("post_rst_value", RData, 64'h00000000DEADBEEF);

    for (int i = 0; i < 40; i++) begin
      bit r_rw;
      logic [7:0] r_addr;
      logic [1:0] r_size;
      logic [63:0] r_wd;
      int r_delay;
      r_rw = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 255));
      r_wd = {32'($urandom), 32'($urandom)};
      r_delay = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      do_req(r_rw, r_addr, r_size, r_wd, r_delay, $sformatf("rnd%0d", i));
    end

    chk("gap_violations", 64'(gap_viol), 64'd0);
    chk("memsize_violations", 64'(size_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
